// File: rtl/prim_clock_switch_pkg.sv
// ============================================================================
// Module      : prim_clock_switch_pkg
// Description : Shared types and constants for the clock-switch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prim_clock_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_OFF    = 2'd1,
        ST_WAIT_SETTLE = 2'd2
    } switch_state_e;

    localparam int c_status_cnt_w = 8;

    // Never returns less than 1 so a counter vector always exists.
    function automatic int calc_cnt_width(input int switch_delay, input int settle_delay);
        int max_delay;
        max_delay = (switch_delay > settle_delay) ? switch_delay : settle_delay;
        if (max_delay < 2) begin
            return 1;
        end
        return $clog2(max_delay);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prim_clock_switch_cnt.sv
// ============================================================================
// Module      : prim_clock_switch_cnt
// Description : Loadable down-counter with zero flag for the switch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_clock_switch_cnt #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (dec_i) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero_o = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/prim_clock_switch_ctrl.sv
// ============================================================================
// Module      : prim_clock_switch_ctrl
// Description : Gate-off / select-flip / settle / gate-on sequencer for a
//               2:1 clock mux. Optional switch counter: CLK_SWITCH_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_clock_switch_ctrl
    import prim_clock_switch_pkg::*;
#(
    parameter int   SWITCH_DELAY = 4,
    parameter int   SETTLE_DELAY = 8,
    parameter logic RESET_SEL    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic req_sel_i,
    input  logic clr_err_i,
    output logic sel_o,
    output logic clk_en_o,
    output logic busy_o,
    output logic done_o,
    output logic err_o
`ifdef CLK_SWITCH_STATUS_EN
    ,
    output logic [c_status_cnt_w-1:0] switch_cnt_o
`endif
);

    localparam int              c_cnt_w      = calc_cnt_width(SWITCH_DELAY, SETTLE_DELAY);
    localparam logic [c_cnt_w-1:0] c_switch_load = c_cnt_w'(SWITCH_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_DELAY - 1);

    switch_state_e      r_state;
    logic               r_sel;
    logic               r_target;
    logic               r_clk_en;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               w_load;
    logic [c_cnt_w-1:0] w_load_val;
    logic               w_dec;
    logic               w_zero;
    logic               w_start;
    logic               w_finish;

    assign w_start  = (r_state == ST_IDLE) && req_i && (req_sel_i != r_sel);
    assign w_finish = (r_state == ST_WAIT_SETTLE) && w_zero;

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_load     = 1'b1;
                    w_load_val = c_switch_load;
                end
            end
            ST_WAIT_OFF: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = c_settle_load;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_WAIT_SETTLE: begin
                w_dec = !w_zero;
            end
            default: begin
                w_dec = 1'b0;
            end
        endcase
    end

    prim_clock_switch_cnt #(
        .WIDTH (c_cnt_w)
    ) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_load),
        .load_val_i (w_load_val),
        .dec_i      (w_dec),
        .zero_o     (w_zero)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_sel    <= RESET_SEL;
            r_target <= RESET_SEL;
            r_clk_en <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        if (req_sel_i != r_sel) begin
                            r_state  <= ST_WAIT_OFF;
                            r_clk_en <= 1'b0;
                            r_busy   <= 1'b1;
                            r_target <= req_sel_i;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_WAIT_OFF: begin
                    if (w_zero) begin
                        r_sel   <= r_target;
                        r_state <= ST_WAIT_SETTLE;
                    end
                end
                ST_WAIT_SETTLE: begin
                    if (w_zero) begin
                        r_clk_en <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A request arriving mid-sequence is dropped; setting beats clearing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (req_i && r_busy) begin
            r_err <= 1'b1;
        end else if (clr_err_i) begin
            r_err <= 1'b0;
        end
    end

`ifdef CLK_SWITCH_STATUS_EN
    logic [c_status_cnt_w-1:0] r_switch_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_switch_cnt <= '0;
        end else if (clr_err_i) begin
            r_switch_cnt <= '0;
        end else if (w_finish && (r_switch_cnt != '1)) begin
            r_switch_cnt <= r_switch_cnt + 1'b1;
        end
    end

    assign switch_cnt_o = r_switch_cnt;
`else
    logic w_unused_finish;
    assign w_unused_finish = w_finish;
`endif

    assign sel_o    = r_sel;
    assign clk_en_o = r_clk_en;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign err_o    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_prim_clock_switch_ctrl.sv
// ============================================================================
// Module      : tb_prim_clock_switch_ctrl
// Description : Self-checking bench for prim_clock_switch_ctrl (default 4/8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prim_clock_switch_ctrl;

    logic clk;
    logic rst;
    logic req;
    logic req_sel;
    logic clr_err;
    logic sel_o;
    logic clk_en_o;
    logic busy_o;
    logic done_o;
    logic err_o;
`ifdef CLK_SWITCH_STATUS_EN
    logic [7:0] switch_cnt_o;
`endif

    int tests;
    int fails;
    logic [4:0] sb_q[$];

    typedef struct {
        logic       req;
        logic       req_sel;
        logic       clr;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[7];

    prim_clock_switch_ctrl u_dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .req_sel_i (req_sel),
        .clr_err_i (clr_err),
        .sel_o     (sel_o),
        .clk_en_o  (clk_en_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
`ifdef CLK_SWITCH_STATUS_EN
        ,
        .switch_cnt_o (switch_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Pops the oldest expectation and compares {sel, clk_en, busy, done, err}.
    task automatic check_outs(input string nm);
        logic [4:0] e;
        logic [4:0] a;
        e = sb_q.pop_front();
        a = {sel_o, clk_en_o, busy_o, done_o, err_o};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: sel/en/busy/done/err got %b expected %b", nm, a, e);
        end
    endtask

    task automatic step(input logic r, input logic rs, input logic c,
                        input logic [4:0] exp, input string nm);
        @(negedge clk);
        req     = r;
        req_sel = rs;
        clr_err = c;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        check_outs(nm);
    endtask

    // Cycle k=0 is the accepting edge E0; steps run through k=last_k.
    task automatic do_switch(input logic tgt, input logic cur, input logic errb,
                             input int err_k, input int clr_k, input int last_k,
                             input string nm);
        logic r, c, e_sel, e_en, e_busy, e_done, e_err;
        for (int k = 0; k <= last_k; k++) begin
            r      = (k == 0) || (k == err_k) || (k == clr_k);
            c      = (k == clr_k);
            e_sel  = (k >= 4) ? tgt : cur;
            e_en   = (k >= 12);
            e_busy = (k < 12);
            e_done = (k == 12);
            e_err  = errb || ((err_k > 0) && (k >= err_k));
            step(r, (k == 0) ? tgt : ~tgt, c, {e_sel, e_en, e_busy, e_done, e_err},
                 $sformatf("%s_k%0d", nm, k));
        end
    endtask

    task automatic fast_switch(input logic tgt);
        @(negedge clk);
        req     = 1'b1;
        req_sel = tgt;
        @(negedge clk);
        req = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        req     = 1'b0;
        req_sel = 1'b0;
        clr_err = 1'b0;

        vecs[0] = '{req: 1'b0, req_sel: 1'b0, clr: 1'b0, exp: 5'b01000};
        vecs[1] = '{req: 1'b1, req_sel: 1'b0, clr: 1'b0, exp: 5'b01010};
        vecs[2] = '{req: 1'b0, req_sel: 1'b0, clr: 1'b0, exp: 5'b01000};
        vecs[3] = '{req: 1'b1, req_sel: 1'b0, clr: 1'b0, exp: 5'b01010};
        vecs[4] = '{req: 1'b1, req_sel: 1'b0, clr: 1'b0, exp: 5'b01010};
        vecs[5] = '{req: 1'b0, req_sel: 1'b0, clr: 1'b1, exp: 5'b01000};
        vecs[6] = '{req: 1'b0, req_sel: 1'b1, clr: 1'b0, exp: 5'b01000};

        repeat (3) @(posedge clk);
        #1;
        sb_q.push_back(5'b01000);
        check_outs("reset_hold");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            step(vecs[i].req, vecs[i].req_sel, vecs[i].clr, vecs[i].exp,
                 $sformatf("vec%0d", i));
        end

        do_switch(1'b1, 1'b0, 1'b0, 0, 0, 13, "sw01");
        do_switch(1'b0, 1'b1, 1'b0, 5, 7, 13, "sw10_err");
        step(1'b0, 1'b0, 1'b1, 5'b01000, "clr_err");

        // Reset lands in WAIT_SETTLE after sel has already flipped.
        do_switch(1'b1, 1'b0, 1'b0, 0, 0, 5, "sw_rst");
        rst = 1'b1;
        #1;
        sb_q.push_back(5'b01000);
        check_outs("async_rst");
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 5'b01000, $sformatf("post_rst%0d", i));
        end

`ifdef CLK_SWITCH_STATUS_EN
        tests++;
        if (switch_cnt_o !== 8'd0) begin
            fails++;
            $display("FAIL cnt_reset: got %0d expected 0", switch_cnt_o);
        end
        do_switch(1'b1, 1'b0, 1'b0, 0, 0, 13, "st_a");
        step(1'b1, 1'b1, 1'b0, 5'b11010, "st_noop1");
        do_switch(1'b0, 1'b1, 1'b0, 0, 0, 13, "st_b");
        step(1'b1, 1'b0, 1'b0, 5'b01010, "st_noop2");
        do_switch(1'b1, 1'b0, 1'b0, 0, 0, 13, "st_c");
        tests++;
        if (switch_cnt_o !== 8'd3) begin
            fails++;
            $display("FAIL cnt_three: got %0d expected 3", switch_cnt_o);
        end
        for (int i = 0; i < 300; i++) begin
            fast_switch(i[0] ? 1'b1 : 1'b0);
        end
        tests++;
        if (switch_cnt_o !== 8'hFF) begin
            fails++;
            $display("FAIL cnt_sat: got %0d expected 255", switch_cnt_o);
        end
        step(1'b0, 1'b0, 1'b1, 5'b11000, "cnt_clr_step");
        tests++;
        if (switch_cnt_o !== 8'd0) begin
            fails++;
            $display("FAIL cnt_clr: got %0d expected 0", switch_cnt_o);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
